// File: rtl/uart_rx_frontend_pkg.sv
// Shared definitions for the Mini UART receive front end:
// FSM state encodings and oversample tick thresholds.
`ifndef UART_RX_FRONTEND_PKG_SV
`define UART_RX_FRONTEND_PKG_SV

package uart_rx_frontend_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Tick index at the middle of the start bit.
    localparam logic [3:0] OVS_MID  = 4'd7;
    // Tick index of the 16th tick of a data/stop bit.
    localparam logic [3:0] OVS_LAST = 4'd15;

endpackage

`endif

// File: rtl/uart_rx_frontend_if.sv
// Register-block side of the receive front end: serial line, tick,
// FIFO head and status flags.
interface uart_rx_frontend_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          RxD;
    logic                          en_rx;
    logic                          read_over;
    logic                          clr_err;
    logic [7:0]                    rx_data;
    logic                          rs;
    logic [$clog2(FIFO_DEPTH):0]   rx_level;
    logic                          fe;
    logic                          oe;
    logic                          busy;

    // Driver of the line and consumer of the FIFO.
    modport master (
        output RxD, en_rx, read_over, clr_err,
        input  rx_data, rs, rx_level, fe, oe, busy
    );

    // The receive front end itself.
    modport slave (
        input  RxD, en_rx, read_over, clr_err,
        output rx_data, rs, rx_level, fe, oe, busy
    );
endinterface

// File: rtl/uart_rx_frontend_fifo.sv
// Small receive FIFO. Pointers carry an extra wrap bit; head is read
// combinationally from memory. Push into a full FIFO only succeeds when
// a pop happens in the same cycle; otherwise push_drop flags the loss.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK_I,
    input  logic                        RST_I,
    input  logic                        push,
    input  logic [7:0]                  din,
    input  logic                        pop,
    output logic [7:0]                  dout,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        push_drop
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Occupancy, status and accept decisions.
    always_comb begin
        empty     = (r_wr_ptr == r_rd_ptr);
        full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        level     = r_wr_ptr - r_rd_ptr;
        dout      = r_mem[r_rd_ptr[AW-1:0]];
        w_do_pop  = pop && !empty;
        w_do_push = push && (!full || w_do_pop);
        push_drop = push && full && !pop;
    end

    // Memory write and pointer advance.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_rx_frontend.sv
// Mini UART receive front end: synchronises RxD, validates the start bit
// at mid-bit, shifts in 8 data bits LSB first, checks one stop bit and
// queues good bytes in the receive FIFO. fe/oe are sticky until clr_err.
module uart_rx_frontend
    import uart_rx_frontend_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVS        = 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    uart_rx_frontend_if.slave bus
);
    if (OVS != 16) begin : g_ovs_check
        $error("uart_rx_frontend supports only OVS = 16");
    end

    logic        r_sync1;
    logic        r_sync2;
    logic        w_rxs;
    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [3:0]  r_tick;
    logic [3:0]  w_tick_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shreg;
    logic [7:0]  w_shreg_nxt;
    logic        w_push;
    logic        w_fe_set;
    logic        w_push_drop;
    logic        w_empty;
    logic        w_full;
    logic        w_unused;
    logic        r_fe;
    logic        r_oe;

    assign w_rxs    = r_sync2;
    assign w_unused = w_full;

    // Two-flop synchroniser; idles high so reset never looks like a start.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.RxD;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state, counters and shift register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= RX_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // Next-state logic; every decision is taken only on an en_rx tick.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_push      = 1'b0;
        w_fe_set    = 1'b0;
        if (bus.en_rx) begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_rxs) begin
                        w_state_nxt = RX_START;
                        w_tick_nxt  = '0;
                    end
                end
                RX_START: begin
                    if (r_tick == OVS_MID) begin
                        w_tick_nxt = '0;
                        if (w_rxs) begin
                            w_state_nxt = RX_IDLE;
                        end else begin
                            w_bit_nxt   = '0;
                            w_state_nxt = RX_DATA;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (r_tick == OVS_LAST) begin
                        w_shreg_nxt = {w_rxs, r_shreg[7:1]};
                        w_tick_nxt  = '0;
                        w_bit_nxt   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = RX_STOP;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (r_tick == OVS_LAST) begin
                        w_state_nxt = RX_IDLE;
                        w_tick_nxt  = '0;
                        if (w_rxs) begin
                            w_push = 1'b1;
                        end else begin
                            w_fe_set = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = RX_IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .push      (w_push),
        .din       (r_shreg),
        .pop       (bus.read_over),
        .dout      (bus.rx_data),
        .empty     (w_empty),
        .full      (w_full),
        .level     (bus.rx_level),
        .push_drop (w_push_drop)
    );

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_fe <= 1'b0;
            r_oe <= 1'b0;
        end else begin
            if (w_fe_set) begin
                r_fe <= 1'b1;
            end else if (bus.clr_err) begin
                r_fe <= 1'b0;
            end
            if (w_push_drop) begin
                r_oe <= 1'b1;
            end else if (bus.clr_err) begin
                r_oe <= 1'b0;
            end
        end
    end

    // Status outputs.
    always_comb begin
        bus.rs   = !w_empty;
        bus.fe   = r_fe;
        bus.oe   = r_oe;
        bus.busy = (r_state != RX_IDLE);
    end
endmodule
